// File: rtl/dp_ram_rd_arb_pkg.sv
// Shared types and helpers for the dual-requester dp_ram read-port arbiter.
// Holds the FSM state encoding, port index constants and one-hot conversion helpers.
package dp_ram_rd_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic [1:0] port_onehot(input logic idx);
        return (idx == PORT1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic onehot_port(input logic [1:0] oh);
        return oh[1] ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dp_ram_rd_arb_if.sv
// Requester handshakes plus the dp_ram read-port connection, bundled for the arbiter.
// The master side is the consumers and the RAM; the slave side is the arbiter itself.
interface dp_ram_rd_arb_if #(
    parameter int adr_width = 11,
    parameter int dat_width = 8,
    parameter int len_width = 4
);
    logic                 req_0;
    logic [adr_width-1:0] adr_0;
    logic [len_width-1:0] len_0;
    logic                 gnt_0;
    logic                 rvalid_0;
    logic                 rlast_0;

    logic                 req_1;
    logic [adr_width-1:0] adr_1;
    logic [len_width-1:0] len_1;
    logic                 gnt_1;
    logic                 rvalid_1;
    logic                 rlast_1;

    logic [dat_width-1:0] rdat;
    logic                 busy;
    logic [adr_width-1:0] ram_adr;
    logic [dat_width-1:0] ram_dat;

    modport master (
        output req_0, adr_0, len_0, req_1, adr_1, len_1, ram_dat,
        input  gnt_0, rvalid_0, rlast_0, gnt_1, rvalid_1, rlast_1, rdat, busy, ram_adr
    );

    modport slave (
        input  req_0, adr_0, len_0, req_1, adr_1, len_1, ram_dat,
        output gnt_0, rvalid_0, rlast_0, gnt_1, rvalid_1, rlast_1, rdat, busy, ram_adr
    );
endinterface

// File: rtl/dp_ram_rd_arb_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the favoured port.
// The favour pointer flips to the other port on every accepted grant.
module rr_arb2
    import dp_ram_rd_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = port_onehot(ptr_q);
        end
        ptr_d = ptr_q;
        if (advance_i && (req_i != 2'b00)) begin
            ptr_d = ~onehot_port(grant_o);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dp_ram_rd_arb.sv
// Shares one dp_ram read port between two burst requesters with round-robin arbitration.
// A granted burst owns the port until its last beat; responses follow the RAM's 1-cycle read latency.
module dp_ram_rd_arb
    import dp_ram_rd_arb_pkg::*;
#(
    parameter int adr_width = 11,
    parameter int dat_width = 8,
    parameter int len_width = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dp_ram_rd_arb_if.slave bus
);

    localparam logic [adr_width-1:0] ADR_ONE = adr_width'(1);
    localparam logic [len_width-1:0] CNT_ONE = len_width'(1);

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic [adr_width-1:0] cur_adr_q, cur_adr_d;
    logic [len_width-1:0] cnt_q, cnt_d;
    logic [1:0]           arb_gnt;
    logic [1:0]           gnt;
    logic                 advance;

    logic                 vld_p1_q;
    logic                 last_p1_q;
    logic                 own_p1_q;
    logic [dat_width-1:0] rdat_p1;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     ({bus.req_1, bus.req_0}),
        .advance_i (advance),
        .grant_o   (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cur_adr_d = cur_adr_q;
        cnt_d     = cnt_q;
        gnt       = 2'b00;
        advance   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                advance = 1'b1;
                if (arb_gnt != 2'b00) begin
                    gnt       = arb_gnt;
                    owner_d   = onehot_port(arb_gnt);
                    cur_adr_d = arb_gnt[1] ? bus.adr_1 : bus.adr_0;
                    cnt_d     = arb_gnt[1] ? bus.len_1 : bus.len_0;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                // The address counter wraps naturally at the top of the RAM.
                cur_adr_d = cur_adr_q + ADR_ONE;
                cnt_d     = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= PORT0;
            cur_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cur_adr_q <= cur_adr_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    // Response stage: aligns beat tags with the data the RAM returns one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            own_p1_q  <= PORT0;
        end else begin
            vld_p1_q  <= (state_q == ST_BURST);
            last_p1_q <= (state_q == ST_BURST) && (cnt_q == '0);
            own_p1_q  <= owner_q;
        end
    end

    assign rdat_p1 = bus.ram_dat;

    assign bus.gnt_0    = gnt[0];
    assign bus.gnt_1    = gnt[1];
    assign bus.rvalid_0 = vld_p1_q  && (own_p1_q == PORT0);
    assign bus.rvalid_1 = vld_p1_q  && (own_p1_q == PORT1);
    assign bus.rlast_0  = last_p1_q && (own_p1_q == PORT0);
    assign bus.rlast_1  = last_p1_q && (own_p1_q == PORT1);
    assign bus.rdat     = rdat_p1;
    assign bus.busy     = (state_q == ST_BURST);
    assign bus.ram_adr  = cur_adr_q;

endmodule

// File: tb/tb_dp_ram_rd_arb.sv
// Bench for dp_ram_rd_arb with a behavioural RAM (mem[i]=i[7:0]) and a transaction-level
// reference model that schedules expected grants and response beats per clock cycle.
module tb_dp_ram_rd_arb;

    localparam int AW = 11;
    localparam int DW = 8;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dp_ram_rd_arb_if #(.adr_width(AW), .dat_width(DW), .len_width(LW)) bus ();

    dp_ram_rd_arb #(.adr_width(AW), .dat_width(DW), .len_width(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [0:2047];
    always @(posedge clk) bus.ram_dat <= mem[bus.ram_adr];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: burst schedule keyed by absolute cycle number.
    bit   m_ptr;
    int   m_free_at;
    int   m_busy_from;
    int   m_busy_to;
    int   rsp_port [int];
    int   rsp_dat  [int];
    bit   rsp_last [int];
    logic [6:0]    e_vec;   // {gnt_1,gnt_0,rvalid_1,rvalid_0,rlast_1,rlast_0,busy}
    logic [DW-1:0] e_dat;
    bit            e_rv;

    function automatic logic [6:0] outs();
        return {bus.gnt_1, bus.gnt_0, bus.rvalid_1, bus.rvalid_0,
                bus.rlast_1, bus.rlast_0, bus.busy};
    endfunction

    task automatic model_eval();
        int w, a, l, p;
        e_vec = '0;
        e_rv  = 1'b0;
        e_dat = '0;
        if (!rst_n) begin
            m_ptr = 1'b0;
            m_free_at = 0;
            m_busy_from = -1;
            m_busy_to = -2;
            rsp_port.delete();
            rsp_dat.delete();
            rsp_last.delete();
            return;
        end
        if (cyc >= m_free_at && (bus.req_0 || bus.req_1)) begin
            if (bus.req_0 && bus.req_1) w = int'(m_ptr);
            else w = bus.req_1 ? 1 : 0;
            m_ptr = (w == 0);
            a = w ? int'(bus.adr_1) : int'(bus.adr_0);
            l = w ? int'(bus.len_1) : int'(bus.len_0);
            for (int k = 0; k <= l; k++) begin
                rsp_port[cyc+2+k] = w;
                rsp_dat[cyc+2+k]  = ((a + k) % 2048) % 256;
                rsp_last[cyc+2+k] = (k == l);
            end
            m_busy_from = cyc + 1;
            m_busy_to   = cyc + 1 + l;
            m_free_at   = cyc + 2 + l;
            e_vec[5+w]  = 1'b1;
        end
        if (rsp_port.exists(cyc)) begin
            p = rsp_port[cyc];
            e_rv = 1'b1;
            e_dat = 8'(rsp_dat[cyc]);
            e_vec[3+p] = 1'b1;
            if (rsp_last[cyc]) e_vec[1+p] = 1'b1;
            rsp_port.delete(cyc);
            rsp_dat.delete(cyc);
            rsp_last.delete(cyc);
        end
        if (cyc >= m_busy_from && cyc <= m_busy_to) e_vec[0] = 1'b1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL reset_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            checks++;
            if (bus.ram_adr !== 11'h000) begin
                failures++;
                $display("FAIL reset_ram_adr cyc=%0d got=%h want=000", cyc, bus.ram_adr);
            end
            adv();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            adv();
        end
    endtask

    task automatic test_single();
        logic [7:0] got[$];
        int t_g = -1;
        int t_l = -1;
        bit drop;
        bus.req_0 = 1'b1;
        bus.adr_0 = 11'h010;
        bus.len_0 = 4'd3;
        for (int i = 0; i < 8; i++) begin
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL single_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            if (e_rv) begin
                checks++;
                if (bus.rdat !== e_dat) begin
                    failures++;
                    $display("FAIL single_rdat cyc=%0d got=%h want=%h", cyc, bus.rdat, e_dat);
                end
            end
            if (bus.rvalid_0) got.push_back(bus.rdat);
            if (bus.gnt_0 && t_g < 0) t_g = cyc;
            if (bus.rlast_0) t_l = cyc;
            drop = e_vec[5];
            adv();
            if (drop) begin
                bus.req_0 = 1'b0;
                bus.adr_0 = 11'($urandom);
                bus.len_0 = 4'($urandom);
            end
        end
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL single_beats got=%0d want=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== 8'(16 + k)) begin
                    failures++;
                    $display("FAIL single_seq beat=%0d got=%h want=%h", k, got[k], 8'(16 + k));
                end
            end
        end
        checks++;
        if (t_g < 0 || (t_l - t_g) != 5) begin
            failures++;
            $display("FAIL single_rlast_time got=%0d want=5", t_l - t_g);
        end
    endtask

    task automatic test_contention();
        int glog[$];
        rst_n = 1'b0;
        sample();
        checks++;
        if (outs() !== e_vec) begin
            failures++;
            $display("FAIL contention_rst cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
        end
        adv();
        rst_n = 1'b1;
        bus.req_0 = 1'b1;
        bus.req_1 = 1'b1;
        bus.len_0 = 4'd0;
        bus.len_1 = 4'd0;
        bus.adr_0 = 11'($urandom);
        bus.adr_1 = 11'($urandom);
        for (int i = 0; i < 13; i++) begin
            if (i == 10) begin
                bus.req_0 = 1'b0;
                bus.req_1 = 1'b0;
            end
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL contention_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            if (e_rv) begin
                checks++;
                if (bus.rdat !== e_dat) begin
                    failures++;
                    $display("FAIL contention_rdat cyc=%0d got=%h want=%h", cyc, bus.rdat, e_dat);
                end
            end
            if (bus.gnt_0) glog.push_back(0);
            if (bus.gnt_1) glog.push_back(1);
            adv();
        end
        checks++;
        if (glog.size() < 4) begin
            failures++;
            $display("FAIL contention_count got=%0d want>=4", glog.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (glog[k] != (k % 2)) begin
                    failures++;
                    $display("FAIL contention_order idx=%0d got=%0d want=%0d", k, glog[k], k % 2);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got[$];
        logic [7:0] want[4];
        logic [7:0] last_dat = 8'h55;
        bit drop;
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00; want[3] = 8'h01;
        bus.req_1 = 1'b1;
        bus.adr_1 = 11'h7FE;
        bus.len_1 = 4'd3;
        for (int i = 0; i < 8; i++) begin
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL wrap_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            if (e_rv) begin
                checks++;
                if (bus.rdat !== e_dat) begin
                    failures++;
                    $display("FAIL wrap_rdat cyc=%0d got=%h want=%h", cyc, bus.rdat, e_dat);
                end
            end
            if (bus.rvalid_1) got.push_back(bus.rdat);
            if (bus.rlast_1) last_dat = bus.rdat;
            drop = e_vec[6];
            adv();
            if (drop) bus.req_1 = 1'b0;
        end
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL wrap_beats got=%0d want=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] !== want[k]) begin
                    failures++;
                    $display("FAIL wrap_seq beat=%0d got=%h want=%h", k, got[k], want[k]);
                end
            end
        end
        checks++;
        if (last_dat !== 8'h01) begin
            failures++;
            $display("FAIL wrap_rlast got=%h want=01", last_dat);
        end
    endtask

    task automatic test_lock();
        int t_g = -1;
        int t1 = -1;
        bit drop0, drop1;
        bus.req_0 = 1'b1;
        bus.adr_0 = 11'($urandom);
        bus.len_0 = 4'd15;
        for (int i = 0; i < 24; i++) begin
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL lock_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            if (e_rv) begin
                checks++;
                if (bus.rdat !== e_dat) begin
                    failures++;
                    $display("FAIL lock_rdat cyc=%0d got=%h want=%h", cyc, bus.rdat, e_dat);
                end
            end
            if (e_vec[5] && t_g < 0) t_g = cyc;
            if (bus.gnt_1 && t1 < 0) t1 = cyc;
            drop0 = e_vec[5];
            drop1 = e_vec[6];
            adv();
            if (drop0) bus.req_0 = 1'b0;
            if (t_g >= 0 && cyc == t_g + 3) begin
                bus.req_1 = 1'b1;
                bus.adr_1 = 11'($urandom);
                bus.len_1 = 4'd0;
            end
            if (drop1) bus.req_1 = 1'b0;
        end
        checks++;
        if (t_g < 0 || (t1 - t_g) != 17) begin
            failures++;
            $display("FAIL lock_gnt1_time got=%0d want=17", t1 - t_g);
        end
    endtask

    task automatic test_reset_mid();
        int t_g = -1;
        int n_rst = 0;
        bit drop;
        bus.req_0 = 1'b1;
        bus.adr_0 = 11'($urandom);
        bus.len_0 = 4'd15;
        for (int i = 0; i < 12; i++) begin
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL rstmid_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            if (!rst_n) begin
                n_rst++;
                checks++;
                if (outs() !== 7'b0 || bus.ram_adr !== 11'h000) begin
                    failures++;
                    $display("FAIL rstmid_clear cyc=%0d got=%b/%h want=0000000/000", cyc, outs(), bus.ram_adr);
                end
            end
            if (e_vec[5] && t_g < 0) t_g = cyc;
            drop = e_vec[5];
            adv();
            if (drop) bus.req_0 = 1'b0;
            if (t_g >= 0 && cyc == t_g + 4) rst_n = 1'b0;
            if (t_g >= 0 && cyc == t_g + 6) rst_n = 1'b1;
        end
        checks++;
        if (n_rst != 2) begin
            failures++;
            $display("FAIL rstmid_window got=%0d want=2", n_rst);
        end
    endtask

    task automatic test_withdraw();
        int t_g = -1;
        int n1 = 0;
        bit drop;
        bus.req_0 = 1'b1;
        bus.adr_0 = 11'($urandom);
        bus.len_0 = 4'd7;
        for (int i = 0; i < 14; i++) begin
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL withdraw_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            if (bus.gnt_1) n1++;
            if (e_vec[5] && t_g < 0) t_g = cyc;
            drop = e_vec[5];
            adv();
            if (drop) bus.req_0 = 1'b0;
            if (t_g >= 0 && cyc == t_g + 2) bus.req_1 = 1'b1;
            if (t_g >= 0 && cyc == t_g + 4) bus.req_1 = 1'b0;
        end
        checks++;
        if (n1 != 0) begin
            failures++;
            $display("FAIL withdraw_gnt1 got=%0d want=0", n1);
        end
    endtask

    task automatic test_random();
        bit drop0, drop1;
        for (int i = 0; i < 420; i++) begin
            if (i >= 400) begin
                bus.req_0 = 1'b0;
                bus.req_1 = 1'b0;
            end
            sample();
            checks++;
            if (outs() !== e_vec) begin
                failures++;
                $display("FAIL random_outs cyc=%0d got=%b want=%b", cyc, outs(), e_vec);
            end
            if (e_rv) begin
                checks++;
                if (bus.rdat !== e_dat) begin
                    failures++;
                    $display("FAIL random_rdat cyc=%0d got=%h want=%h", cyc, bus.rdat, e_dat);
                end
            end
            drop0 = e_vec[5];
            drop1 = e_vec[6];
            adv();
            if (i < 399) begin
                if (drop0 || (bus.req_0 && $urandom_range(0, 15) == 0)) bus.req_0 = 1'b0;
                else if (!bus.req_0 && $urandom_range(0, 2) == 0) bus.req_0 = 1'b1;
                if (drop1 || (bus.req_1 && $urandom_range(0, 15) == 0)) bus.req_1 = 1'b0;
                else if (!bus.req_1 && $urandom_range(0, 2) == 0) bus.req_1 = 1'b1;
                bus.adr_0 = 11'($urandom);
                bus.adr_1 = 11'($urandom);
                bus.len_0 = 4'($urandom_range(0, 15));
                bus.len_1 = 4'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        rst_n     = 1'b0;
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
        bus.adr_0 = '0;
        bus.adr_1 = '0;
        bus.len_0 = '0;
        bus.len_1 = '0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_lock();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
